// File: rtl/vga_cmd_pkg.sv
// Shared codes and sizing for the VGA command queue: write types, field selects,
// drain FSM states and the FIFO entry width.
package vga_cmd_pkg;

  localparam logic [1:0] SPR = 2'b00;
  localparam logic [1:0] FNT = 2'b01;
  localparam logic [1:0] BKG = 2'b10;

  localparam logic [1:0] BASE = 2'b00;
  localparam logic [1:0] POS  = 2'b01;
  localparam logic [1:0] ATTR = 2'b10;
  localparam logic [1:0] VISI = 2'b11;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  localparam int TYPE_W       = 2;
  localparam int MASK_W       = 3;
  localparam int DATA_W       = 32;
  localparam int IDXW_DEFAULT = 6;
  localparam int ENTRY_W      = TYPE_W + MASK_W + IDXW_DEFAULT + DATA_W;

  // Entry layout, MSB first: {type, mask{pos,attr,visi}, index, data}
  function automatic int entry_width(input int idxw);
    return TYPE_W + MASK_W + idxw + DATA_W;
  endfunction

endpackage

// File: rtl/vga_cmd_fifo.sv
// Synchronous DEPTH x WIDTH FIFO with registered full/empty flags and an
// occupancy count; the head entry is always visible on dout_o.
module vga_cmd_fifo
  import vga_cmd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = ENTRY_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = 1;
  localparam logic [PTR_W:0]   CNT_ONE   = 1;
  localparam logic [PTR_W:0]   CNT_DEPTH = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  // Guard against over/underflow even if the caller ignores the flags
  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
      full_q  <= (count_d == CNT_DEPTH);
      empty_q <= (count_d == '0);
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;

endmodule

// File: rtl/vga_cmd_queue.sv
// Buffers VGA sprite/font/background commands from E and replays them as
// single-field writes over req/ack. Optional macro VGA_CMD_BLANK_ONLY_EN.
module vga_cmd_queue
  import vga_cmd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDXW  = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            spriteE,
  input  logic            fontE,
  input  logic            backgroundE,
  input  logic            posE,
  input  logic            attrE,
  input  logic            visiE,
  input  logic            stallM,
  input  logic            flushM,
  input  logic [31:0]     cmd_a,
  input  logic [31:0]     cmd_b,
  output logic            vga_stall,
  output logic            wr_req,
  input  logic            wr_ack,
  output logic [1:0]      wr_type,
  output logic [1:0]      wr_field,
  output logic [IDXW-1:0] wr_index,
  output logic [31:0]     wr_data,
  input  logic            vblank,
  output logic            q_empty
);

  localparam int EW = entry_width(IDXW);

  logic          cmd_e, push, pop;
  logic [1:0]    type_e;
  logic [EW-1:0] fifo_din, fifo_dout;
  logic          fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic          drain_gate;

  logic [0:0]      state_q, state_d;
  logic [1:0]      work_type_q, work_type_d;
  logic [2:0]      work_mask_q, work_mask_d;
  logic [IDXW-1:0] work_idx_q, work_idx_d;
  logic [31:0]     work_data_q, work_data_d;
  logic [1:0]      field_sel;
  logic [2:0]      field_bit, mask_rem;

  logic [31-IDXW:0]     unused_cmd_a;
  logic [$clog2(DEPTH):0] unused_count;
  assign unused_cmd_a = cmd_a[31:IDXW];
  assign unused_count = fifo_count;

`ifdef VGA_CMD_BLANK_ONLY_EN
  assign drain_gate = vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign drain_gate    = 1'b1;
`endif

  assign cmd_e     = spriteE | fontE | backgroundE;
  assign push      = cmd_e & ~stallM & ~flushM & ~fifo_full;
  assign vga_stall = cmd_e & fifo_full;

  always_comb begin
    type_e = BKG;
    if (spriteE)    type_e = SPR;
    else if (fontE) type_e = FNT;
  end

  assign fifo_din = {type_e, posE, attrE, visiE, cmd_a[IDXW-1:0], cmd_b};

  vga_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (fifo_din),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Mask bits are {pos, attr, visi}; pos has priority, an empty mask means base
  always_comb begin
    field_sel = BASE;
    field_bit = 3'b000;
    if (work_mask_q[2]) begin
      field_sel = POS;
      field_bit = 3'b100;
    end else if (work_mask_q[1]) begin
      field_sel = ATTR;
      field_bit = 3'b010;
    end else if (work_mask_q[0]) begin
      field_sel = VISI;
      field_bit = 3'b001;
    end
  end

  assign mask_rem = work_mask_q & ~field_bit;

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    work_type_d = work_type_q;
    work_mask_d = work_mask_q;
    work_idx_d  = work_idx_q;
    work_data_d = work_data_q;
    case (state_q)
      ST_IDLE: begin
        if (~fifo_empty && drain_gate) begin
          pop     = 1'b1;
          state_d = ST_ISSUE;
          {work_type_d, work_mask_d, work_idx_d, work_data_d} = fifo_dout;
        end
      end
      default: begin
        if (wr_ack) begin
          work_mask_d = mask_rem;
          if (mask_rem == 3'b000) begin
            // Chain straight into the next entry to keep one write per cycle
            if (~fifo_empty && drain_gate) begin
              pop = 1'b1;
              {work_type_d, work_mask_d, work_idx_d, work_data_d} = fifo_dout;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      work_type_q <= '0;
      work_mask_q <= '0;
      work_idx_q  <= '0;
      work_data_q <= '0;
    end else begin
      state_q     <= state_d;
      work_type_q <= work_type_d;
      work_mask_q <= work_mask_d;
      work_idx_q  <= work_idx_d;
      work_data_q <= work_data_d;
    end
  end

  assign wr_req   = (state_q == ST_ISSUE);
  assign wr_type  = work_type_q;
  assign wr_field = field_sel;
  assign wr_index = work_idx_q;
  assign wr_data  = work_data_q;
  assign q_empty  = fifo_empty;

endmodule

// File: tb/tb_vga_cmd_queue.sv
// Directed bench for vga_cmd_queue: latency, mask expansion, full stall,
// squash, reset mid-write and (when the macro is set) vblank gating.
module tb_vga_cmd_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        spriteE, fontE, backgroundE;
  logic        posE, attrE, visiE;
  logic        stallM, flushM;
  logic [31:0] cmd_a, cmd_b;
  logic        vga_stall, wr_req, wr_ack;
  logic [1:0]  wr_type, wr_field;
  logic [5:0]  wr_index;
  logic [31:0] wr_data;
  logic        vblank, q_empty;

  int checks = 0;
  int errors = 0;
  logic [41:0] cap_q[$];

  always #5 clk = ~clk;

  vga_cmd_queue #(.DEPTH(8), .IDXW(6)) dut (
    .clk(clk), .reset(reset),
    .spriteE(spriteE), .fontE(fontE), .backgroundE(backgroundE),
    .posE(posE), .attrE(attrE), .visiE(visiE),
    .stallM(stallM), .flushM(flushM),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .vga_stall(vga_stall),
    .wr_req(wr_req), .wr_ack(wr_ack),
    .wr_type(wr_type), .wr_field(wr_field), .wr_index(wr_index), .wr_data(wr_data),
    .vblank(vblank), .q_empty(q_empty)
  );

  // A write is accepted at the next rising edge when req and ack are both high
  always @(negedge clk) begin
    if (!reset && wr_req && wr_ack) begin
      cap_q.push_back({wr_type, wr_field, wr_index, wr_data});
      $display("write type=%0d field=%0d index=%0d data=%h", wr_type, wr_field, wr_index, wr_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cmd();
    spriteE = 0; fontE = 0; backgroundE = 0;
    posE = 0; attrE = 0; visiE = 0;
    cmd_a = 0; cmd_b = 0;
  endtask

  task automatic test_reset();
    reset = 1; wr_ack = 0; stallM = 0; flushM = 0; vblank = 0;
    clear_cmd();
    tick(); tick();
    checks++;
    if ({vga_stall, wr_req, wr_type, wr_field, wr_index, wr_data} !== 44'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", {vga_stall, wr_req, wr_type, wr_field, wr_index, wr_data});
    end
    checks++;
    if (q_empty !== 1'b1) begin errors++; $display("FAIL reset_q_empty: got %b expected 1", q_empty); end
    reset = 0;
    tick();
  endtask

  task automatic test_single();
    logic [41:0] exp_w;
    exp_w = {2'b00, 2'b01, 6'd5, 32'h0064_0032};
    cap_q.delete();
    spriteE = 1; posE = 1; cmd_a = 32'd5; cmd_b = 32'h0064_0032;
    tick();
    clear_cmd();
    checks++;
    if (wr_req !== 1'b0) begin errors++; $display("FAIL single_req_early: got %b expected 0", wr_req); end
    checks++;
    if (q_empty !== 1'b0) begin errors++; $display("FAIL single_q_nonempty: got %b expected 0", q_empty); end
    tick();
    checks++;
    if ({wr_req, wr_type, wr_field, wr_index, wr_data} !== {1'b1, exp_w}) begin
      errors++;
      $display("FAIL single_issue: got %h expected %h", {wr_req, wr_type, wr_field, wr_index, wr_data}, {1'b1, exp_w});
    end
    wr_ack = 1;
    tick();
    wr_ack = 0;
    checks++;
    if (wr_req !== 1'b0) begin errors++; $display("FAIL single_req_drop: got %b expected 0", wr_req); end
    checks++;
    if (cap_q.size() != 1 || cap_q[0] !== exp_w) begin
      errors++;
      $display("FAIL single_write: got n=%0d first=%h expected n=1 %h", cap_q.size(), (cap_q.size() > 0) ? cap_q[0] : 42'd0, exp_w);
    end
  endtask

  task automatic test_mask_expansion();
    logic [41:0] exp_w [4];
    exp_w[0] = {2'b01, 2'b01, 6'd3, 32'h0000_00A5};
    exp_w[1] = {2'b01, 2'b10, 6'd3, 32'h0000_00A5};
    exp_w[2] = {2'b01, 2'b11, 6'd3, 32'h0000_00A5};
    exp_w[3] = {2'b10, 2'b00, 6'd7, 32'h1234_5678};
    cap_q.delete();
    wr_ack = 1;
    fontE = 1; posE = 1; attrE = 1; visiE = 1; cmd_a = 32'd3; cmd_b = 32'hA5;
    tick();
    clear_cmd();
    backgroundE = 1; cmd_a = 32'd7; cmd_b = 32'h1234_5678;
    tick();
    clear_cmd();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({wr_req, wr_type, wr_field, wr_index, wr_data} !== {1'b1, exp_w[i]}) begin
        errors++;
        $display("FAIL mask_cycle%0d: got %h expected %h", i, {wr_req, wr_type, wr_field, wr_index, wr_data}, {1'b1, exp_w[i]});
      end
      tick();
    end
    wr_ack = 0;
    checks++;
    if (wr_req !== 1'b0 || q_empty !== 1'b1) begin
      errors++;
      $display("FAIL mask_done: got req=%b empty=%b expected req=0 empty=1", wr_req, q_empty);
    end
    checks++;
    if (cap_q.size() != 4) begin errors++; $display("FAIL mask_count: got %0d expected 4", cap_q.size()); end
  endtask

  task automatic test_full_stall();
    int n;
    cap_q.delete();
    wr_ack = 0;
    for (int i = 0; i < 9; i++) begin
      spriteE = 1; attrE = 1; cmd_a = i; cmd_b = 32'h100 + i;
      tick();
    end
    spriteE = 1; attrE = 1; cmd_a = 32'd9; cmd_b = 32'h109;
    #1;
    checks++;
    if (vga_stall !== 1'b1) begin errors++; $display("FAIL full_stall_on: got %b expected 1", vga_stall); end
    tick();
    checks++;
    if (vga_stall !== 1'b1 || cap_q.size() != 0) begin
      errors++;
      $display("FAIL full_stall_hold: got stall=%b writes=%0d expected stall=1 writes=0", vga_stall, cap_q.size());
    end
    wr_ack = 1;
    tick();
    checks++;
    if (vga_stall !== 1'b0) begin errors++; $display("FAIL full_stall_clear: got %b expected 0", vga_stall); end
    tick();
    clear_cmd();
    n = 0;
    while (!(q_empty && !wr_req) && n < 40) begin tick(); n++; end
    wr_ack = 0;
    checks++;
    if (n >= 40) begin errors++; $display("FAIL full_drain_timeout: got %0d cycles expected < 40", n); end
    checks++;
    if (cap_q.size() != 10) begin errors++; $display("FAIL full_write_count: got %0d expected 10", cap_q.size()); end
    for (int i = 0; i < 10 && i < cap_q.size(); i++) begin
      logic [41:0] e;
      e = {2'b00, 2'b10, 6'(i), 32'h100 + 32'(i)};
      checks++;
      if (cap_q[i] !== e) begin errors++; $display("FAIL full_order%0d: got %h expected %h", i, cap_q[i], e); end
    end
  endtask

  task automatic test_squash();
    cap_q.delete();
    wr_ack = 1;
    spriteE = 1; visiE = 1; cmd_a = 32'd11; cmd_b = 32'h55;
    flushM = 1;
    tick(); tick();
    flushM = 0;
    checks++;
    if (q_empty !== 1'b1 || wr_req !== 1'b0) begin
      errors++;
      $display("FAIL squash_flush: got empty=%b req=%b expected empty=1 req=0", q_empty, wr_req);
    end
    stallM = 1;
    tick(); tick();
    checks++;
    if (q_empty !== 1'b1) begin errors++; $display("FAIL squash_stall: got empty=%b expected 1", q_empty); end
    stallM = 0;
    tick();
    clear_cmd();
    tick(); tick(); tick();
    wr_ack = 0;
    checks++;
    if (cap_q.size() != 1 || cap_q[0] !== {2'b00, 2'b11, 6'd11, 32'h55}) begin
      errors++;
      $display("FAIL squash_one_push: got n=%0d first=%h expected n=1 %h", cap_q.size(),
               (cap_q.size() > 0) ? cap_q[0] : 42'd0, {2'b00, 2'b11, 6'd11, 32'h55});
    end
  endtask

  task automatic test_reset_mid();
    cap_q.delete();
    wr_ack = 0;
    backgroundE = 1; visiE = 1; cmd_a = 32'd9; cmd_b = 32'hDEAD_0001;
    tick();
    cmd_b = 32'hDEAD_0002;
    tick();
    clear_cmd();
    checks++;
    if (wr_req !== 1'b1 || wr_type !== 2'b10 || q_empty !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_pre: got req=%b type=%0d empty=%b expected req=1 type=2 empty=0", wr_req, wr_type, q_empty);
    end
    reset = 1;
    tick();
    checks++;
    if ({wr_req, wr_type, wr_field, wr_index, wr_data, q_empty} !== 44'd1) begin
      errors++;
      $display("FAIL rstmid_clear: got %h expected 1", {wr_req, wr_type, wr_field, wr_index, wr_data, q_empty});
    end
    reset = 0;
    tick();
    wr_ack = 1;
    spriteE = 1; posE = 1; cmd_a = 32'd1; cmd_b = 32'h77;
    tick();
    clear_cmd();
    tick(); tick(); tick();
    wr_ack = 0;
    checks++;
    if (cap_q.size() != 1 || cap_q[0] !== {2'b00, 2'b01, 6'd1, 32'h77}) begin
      errors++;
      $display("FAIL rstmid_after: got n=%0d first=%h expected n=1 %h", cap_q.size(),
               (cap_q.size() > 0) ? cap_q[0] : 42'd0, {2'b00, 2'b01, 6'd1, 32'h77});
    end
  endtask

`ifdef VGA_CMD_BLANK_ONLY_EN
  task automatic test_blank_only();
    cap_q.delete();
    wr_ack = 0; vblank = 0;
    for (int i = 0; i < 2; i++) begin
      spriteE = 1; posE = 1; attrE = 1; cmd_a = 20 + i; cmd_b = 32'hB0 + i;
      tick();
    end
    clear_cmd();
    tick(); tick();
    checks++;
    if (wr_req !== 1'b0) begin errors++; $display("FAIL blank_hold: got req=%b expected 0", wr_req); end
    vblank = 1;
    tick();
    checks++;
    if (wr_req !== 1'b1 || wr_index !== 6'd20) begin
      errors++;
      $display("FAIL blank_start: got req=%b index=%0d expected req=1 index=20", wr_req, wr_index);
    end
    vblank = 0; wr_ack = 1;
    tick(); tick();
    checks++;
    if (wr_req !== 1'b0 || cap_q.size() != 2) begin
      errors++;
      $display("FAIL blank_first_done: got req=%b writes=%0d expected req=0 writes=2", wr_req, cap_q.size());
    end
    tick();
    checks++;
    if (wr_req !== 1'b0 || q_empty !== 1'b0) begin
      errors++;
      $display("FAIL blank_second_wait: got req=%b empty=%b expected req=0 empty=0", wr_req, q_empty);
    end
    vblank = 1;
    tick(); tick(); tick();
    wr_ack = 0; vblank = 0;
    checks++;
    if (cap_q.size() != 4 || cap_q[3] !== {2'b00, 2'b10, 6'd21, 32'hB1}) begin
      errors++;
      $display("FAIL blank_second: got n=%0d expected n=4 last=%h", cap_q.size(), {2'b00, 2'b10, 6'd21, 32'hB1});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_mask_expansion();
    test_full_stall();
    test_squash();
    test_reset_mid();
`ifdef VGA_CMD_BLANK_ONLY_EN
    test_blank_only();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
